// File: rtl/dvs_pkg.sv
// Shared types and helpers for the DVS event accumulator.
//   state_e      : accumulator FSM states
//   ts_t         : 16-bit wrapping event timestamp
//   sat_inc_dec  : +/-1 step on a two's complement count of width cw,
//                  clamped at the most positive and most negative values
package dvs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [15:0] ts_t;

  // The count arrives sign-extended to 32 bits; the caller truncates the
  // result back to cw bits, which is lossless because it is clamped.
  function automatic logic signed [31:0] sat_inc_dec(
    input logic signed [31:0] count,
    input logic               polarity,
    input int unsigned        cw
  );
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (cw - 1)) - 32'sd1;
    min_v = -(32'sd1 <<< (cw - 1));
    if (polarity) return (count >= max_v) ? max_v : count + 32'sd1;
    else          return (count <= min_v) ? min_v : count - 32'sd1;
  endfunction

endpackage

// File: rtl/dvs_event_accumulator.sv
// Integrates DVS events into a signed saturating per-pixel count frame over a
// timestamp window, then streams the frame out row-major, clearing each pixel
// as it is read.
//
// state | meaning
// IDLE  | frame empty, waiting for the first event of a window
// ACCUM | window open, events applied while inside [ws, ws+WINDOW_P)
// DRAIN | frame streamed out on valid_o/ready_i, input stalled
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   valid_i/ready_o, x_i, y_i,
//   polarity_i, timestamp_i             event input stream
//   flush_i                             close the open window early
//   valid_o/ready_i, data_o, x_o, y_o,
//   last_o                              frame output stream
module dvs_event_accumulator
  import dvs_pkg::*;
#(
  parameter int WIDTH_P       = 8,
  parameter int HEIGHT_P      = 8,
  parameter int COUNT_WIDTH_P = 8,
  parameter int WINDOW_P      = 1000,
  localparam int XW = $clog2(WIDTH_P),
  localparam int YW = $clog2(HEIGHT_P)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            valid_i,
  input  logic [XW-1:0]                   x_i,
  input  logic [YW-1:0]                   y_i,
  input  logic                            polarity_i,
  input  logic [15:0]                     timestamp_i,
  output logic                            ready_o,
  input  logic                            flush_i,
  output logic                            valid_o,
  output logic signed [COUNT_WIDTH_P-1:0] data_o,
  output logic [XW-1:0]                   x_o,
  output logic [YW-1:0]                   y_o,
  output logic                            last_o,
  input  logic                            ready_i
);

  localparam int NUM_PIX = WIDTH_P * HEIGHT_P;
  localparam int IW      = $clog2(NUM_PIX);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIX - 1);

  state_e                          state_q, state_d;
  logic signed [COUNT_WIDTH_P-1:0] cnt_q [NUM_PIX];
  logic signed [COUNT_WIDTH_P-1:0] cnt_d [NUM_PIX];
  ts_t                             ws_q, ws_d;
  logic                            pend_vld_q, pend_vld_d;
  logic [XW-1:0]                   pend_x_q, pend_x_d;
  logic [YW-1:0]                   pend_y_q, pend_y_d;
  logic                            pend_pol_q, pend_pol_d;
  ts_t                             pend_ts_q, pend_ts_d;
  logic [IW-1:0]                   rd_idx_q, rd_idx_d;

  logic          accept, in_win, pix_hs, in_range;
  ts_t           elapsed;
  logic          apply_en, apply_pol;
  logic [XW-1:0] apply_x;
  logic [YW-1:0] apply_y;
  logic [IW-1:0] apply_idx;

  assign ready_o = (state_q != DRAIN);
  assign accept  = valid_i && ready_o;
  assign elapsed = timestamp_i - ws_q;  // modular, tolerates one wrap
  assign in_win  = ({16'd0, elapsed} < 32'(WINDOW_P));
  assign pix_hs  = (state_q == DRAIN) && ready_i;

  always_comb begin
    state_d    = state_q;
    ws_d       = ws_q;
    pend_vld_d = pend_vld_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_pol_d = pend_pol_q;
    pend_ts_d  = pend_ts_q;
    rd_idx_d   = rd_idx_q;
    apply_en   = 1'b0;
    apply_x    = x_i;
    apply_y    = y_i;
    apply_pol  = polarity_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ws_d     = timestamp_i;
          apply_en = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && !in_win) begin
          // The closing event opens the next window once the frame drains.
          pend_vld_d = 1'b1;
          pend_x_d   = x_i;
          pend_y_d   = y_i;
          pend_pol_d = polarity_i;
          pend_ts_d  = timestamp_i;
          state_d    = DRAIN;
        end else begin
          apply_en = accept;
          if (flush_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ready_i) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            if (pend_vld_q) begin
              ws_d       = pend_ts_q;
              apply_en   = 1'b1;
              apply_x    = pend_x_q;
              apply_y    = pend_y_q;
              apply_pol  = pend_pol_q;
              pend_vld_d = 1'b0;
              state_d    = ACCUM;
            end else begin
              state_d = IDLE;
            end
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign apply_idx = IW'(32'(apply_y) * WIDTH_P + 32'(apply_x));
  assign in_range  = (32'(apply_x) < WIDTH_P) && (32'(apply_y) < HEIGHT_P);

  // Clear happens before apply so a pending event landing on the last pixel
  // starts from zero.
  always_comb begin
    for (int i = 0; i < NUM_PIX; i++) cnt_d[i] = cnt_q[i];
    if (pix_hs) cnt_d[rd_idx_q] = '0;
    if (apply_en && in_range)
      cnt_d[apply_idx] = COUNT_WIDTH_P'(sat_inc_dec(32'(cnt_d[apply_idx]),
                                                    apply_pol, COUNT_WIDTH_P));
  end

  assign valid_o = (state_q == DRAIN);
  assign data_o  = cnt_q[rd_idx_q];
  assign x_o     = XW'(32'(rd_idx_q) % WIDTH_P);
  assign y_o     = YW'(32'(rd_idx_q) / WIDTH_P);
  assign last_o  = valid_o && (rd_idx_q == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ws_q       <= '0;
      pend_vld_q <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_pol_q <= 1'b0;
      pend_ts_q  <= '0;
      rd_idx_q   <= '0;
      for (int i = 0; i < NUM_PIX; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ws_q       <= ws_d;
      pend_vld_q <= pend_vld_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_pol_q <= pend_pol_d;
      pend_ts_q  <= pend_ts_d;
      rd_idx_q   <= rd_idx_d;
      for (int i = 0; i < NUM_PIX; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_dvs_event_accumulator.sv
module tb_dvs_event_accumulator;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              valid_i = 1'b0;
  logic [1:0]        x_i = '0;
  logic [1:0]        y_i = '0;
  logic              polarity_i = 1'b0;
  logic [15:0]       timestamp_i = '0;
  logic              ready_o;
  logic              flush_i = 1'b0;
  logic              valid_o;
  logic signed [7:0] data_o;
  logic [1:0]        x_o;
  logic [1:0]        y_o;
  logic              last_o;
  logic              ready_i = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  logic signed [7:0] exp_frame [16];

  dvs_event_accumulator #(
    .WIDTH_P(4), .HEIGHT_P(4), .COUNT_WIDTH_P(8), .WINDOW_P(100)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .x_i(x_i), .y_i(y_i),
    .polarity_i(polarity_i), .timestamp_i(timestamp_i), .ready_o(ready_o),
    .flush_i(flush_i), .valid_o(valid_o), .data_o(data_o), .x_o(x_o),
    .y_o(y_o), .last_o(last_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_frame[i] = 8'sd0;
  endtask

  task automatic send(input int x, input int y, input bit pol, input int ts);
    @(negedge clk);
    chk("ready_before_event", 32'(ready_o), 1);
    valid_i = 1'b1; x_i = 2'(x); y_i = 2'(y); polarity_i = pol;
    timestamp_i = 16'(ts);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  // Reads a full frame against exp_frame. With stall set, ready_i follows the
  // pattern 1,0,0,1 and a bogus event is offered on every cycle.
  task automatic drain_check(input bit stall);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      @(negedge clk);
      rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      chk("drain_valid", 32'(valid_o), 1);
      chk("drain_ready_o", 32'(ready_o), 0);
      chk($sformatf("drain_data_%0d", idx), data_o, exp_frame[idx]);
      chk("drain_x", 32'(x_o), idx % 4);
      chk("drain_y", 32'(y_o), idx / 4);
      chk("drain_last", 32'(last_o), (idx == 15) ? 1 : 0);
      ready_i = rdy;
      if (stall) begin
        valid_i = 1'b1; x_i = 2'd3; y_i = 2'd3; polarity_i = 1'b1;
        timestamp_i = 16'd100;
      end
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("drain_completed", idx, 16);
    @(negedge clk);
    chk("post_drain_valid", 32'(valid_o), 0);
    chk("post_drain_ready_o", 32'(ready_o), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_o", 32'(valid_o), 0);
    chk("reset_ready_o", 32'(ready_o), 1);
    chk("reset_last_o", 32'(last_o), 0);
    chk("reset_data_o", data_o, 0);
    chk("reset_x_o", 32'(x_o), 0);
    chk("reset_y_o", 32'(y_o), 0);
    reset_i = 1'b0;

    // Basic accumulation closed by flush
    send(1, 2, 1'b1, 10);
    send(1, 2, 1'b1, 20);
    send(3, 0, 1'b0, 30);
    flush();
    clear_exp();
    exp_frame[9] = 8'sd2;
    exp_frame[3] = -8'sd1;
    drain_check(1'b0);

    // ON then OFF on one pixel: frame must come back all zero
    send(0, 0, 1'b1, 200);
    send(0, 0, 1'b0, 201);
    flush();
    clear_exp();
    drain_check(1'b0);

    // Window closed by timestamp; elapsed 100 is out, 99 is in
    send(0, 0, 1'b1, 10);
    send(1, 0, 1'b1, 110);
    clear_exp();
    exp_frame[0] = 8'sd1;
    drain_check(1'b0);
    send(2, 0, 1'b1, 209);
    flush();
    clear_exp();
    exp_frame[1] = 8'sd1;
    exp_frame[2] = 8'sd1;
    drain_check(1'b0);

    // Saturation both ways
    for (int i = 0; i < 130; i++) send(2, 2, 1'b1, 300);
    flush();
    clear_exp();
    exp_frame[10] = 8'sd127;
    drain_check(1'b0);
    for (int i = 0; i < 130; i++) send(2, 2, 1'b0, 400);
    flush();
    clear_exp();
    exp_frame[10] = -8'sd128;
    drain_check(1'b0);

    // Timestamp wrap, drained under backpressure
    send(0, 0, 1'b1, 65530);
    send(1, 1, 1'b1, 5);
    send(2, 1, 1'b1, 95);
    clear_exp();
    exp_frame[0] = 8'sd1;
    exp_frame[5] = 8'sd1;
    drain_check(1'b1);
    flush();
    clear_exp();
    exp_frame[6] = 8'sd1;
    drain_check(1'b0);

    // Reset mid-drain with a pending event
    send(1, 1, 1'b1, 1000);
    send(2, 2, 1'b1, 1200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pre_reset_valid", 32'(valid_o), 1);
      chk("pre_reset_data", data_o, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre_reset_data_5", data_o, 1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid_o", 32'(valid_o), 0);
    chk("mid_reset_ready_o", 32'(ready_o), 1);
    chk("mid_reset_data_o", data_o, 0);
    send(0, 0, 1'b1, 50);
    flush();
    clear_exp();
    exp_frame[0] = 8'sd1;
    drain_check(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
